trail_collision_scheduler: RTL and testbench
============================================

// Module: trail_collision_scheduler
// PURPOSE
//  Time-multiplexes one rectangle-overlap comparator across all trail cells,
//  replacing a fully parallel per-cell compare. The game controller issues a
//  scan request; the block snapshots pig box and trail vectors, walks the cells
//  one per cycle, and reports hit/index with a done pulse. Sits between
//  trail_locator and the game_over logic.
// PARAMETERS
//  TRAIL_POINTS  16   number of trail cells in trailX/trailY
//  BIT_WIDTH     5    bits per packed cell coordinate (grid units)
//  TRAIL_WIDTH   20   pixel size of one grid cell
//  EMPTY_CODE    31   coordinate value marking an unused cell
//  COORD_W       10   pixel coordinate width
//  IDX_W         4    width of hit_index; must be >= clog2(TRAIL_POINTS)
// PORTS
//  clk        in   1                     system clock
//  RST        in   1                     reset, synchronous, active-low
//  abort      in   1                     cancel scan in progress, sync, active-high
//  scan_req   in   1                     start request, sampled only in IDLE
//  pigX       in   COORD_W               pig box left
//  pigY       in   COORD_W               pig box top
//  pigX_end   in   COORD_W               pig box right
//  pigY_end   in   COORD_W               pig box bottom
//  trailX     in   TRAIL_POINTS*BIT_WIDTH  packed cell X, cell i at [BIT_WIDTH*i +: BIT_WIDTH]
//  trailY     in   TRAIL_POINTS*BIT_WIDTH  packed cell Y, same packing
//  scan_busy  out  1                     high while in SCAN
//  scan_done  out  1                     one-cycle pulse on scan completion
//  hit        out  1                     result of last completed scan
//  hit_index  out  IDX_W                 lowest overlapping cell index, else 0
// BEHAVIOUR
//  - Reset: when RST is low at a clk edge, go to IDLE. Reset values:
//    scan_busy=0, scan_done=0, hit=0, hit_index=0, idx=0. RST overrides abort
//    and scan_req.
//  - FSM states: IDLE, SCAN.
//  - IDLE: when scan_req=1 at an edge, latch pig box, trailX and trailY into
//    snapshot registers. Set idx=0 and go to SCAN.
//  - Snapshot rule: input changes during SCAN have no effect on the result.
//  - SCAN: each cycle, evaluate snapshot cell idx.
//    - Cell is skipped (no hit) if X==EMPTY_CODE or Y==EMPTY_CODE.
//    - Axis overlap, with lo=TRAIL_WIDTH*c and hi=lo+TRAIL_WIDTH, is true if
//      any of: (p>lo && p<hi), (pe>lo && pe<hi), (p<=lo && pe>=hi).
//    - Hit = X-axis overlap AND Y-axis overlap.
//    - Compute lo/hi in COORD_W+2 bits; no truncation.
//  - Termination: at the edge ending evaluation of cell i, if it hit or
//    i==TRAIL_POINTS-1:
//    - scan_done<=1 for one cycle; hit<=cell i hit; hit_index<=hit?i:0.
//    - Return to IDLE.
//    - Otherwise idx<=i+1.
//  - Latency: if the request is accepted at edge E0 and the first hit is cell
//    i, scan_done is high in the cycle after edge E(i+1). With no hit, it is
//    high after edge E(TRAIL_POINTS).
//  - scan_busy=1 exactly while in SCAN; it is 0 in the scan_done cycle.
//  - scan_req during SCAN is ignored (no queueing). scan_req in the scan_done
//    cycle is accepted, so back-to-back scans run with zero idle cycles.
//  - hit and hit_index hold until the next scan_done or reset.
//  - abort=1 in SCAN: return to IDLE at that edge; no scan_done; hit and
//    hit_index keep their old values. abort in IDLE has priority over scan_req
//    (request dropped).
// TESTING
//  - Reset: hold RST=0 for 3 cycles with scan_req=1 -> all outputs 0, no
//    scan_done; release -> request accepted next edge.
//  - All cells 31 with pig at (100,100)-(119,119) -> scan_done after 16 SCAN
//    cycles, hit=0, hit_index=0.
//  - Cell 5=(5,5) (pixels 100..120), pig (105,105)-(124,124) -> scan_done after
//    6 SCAN cycles, hit=1, hit_index=5; cell 9 also overlapping -> still index 5.
//  - Edge-touch: cell 2=(3,3) (60..80), pig (80,80)-(99,99) -> hit=0, because
//    the bounds are strict.
//  - Change trailX mid-scan so cell 10 overlaps -> result unchanged (snapshot).
//    scan_req pulses during SCAN -> ignored.
//  - abort at SCAN idx=7 after a prior hit=1,index=3 -> IDLE, no scan_done,
//    hit=1, hit_index=3 retained.

Source files
------------

// File: rtl/trail_collision_scheduler_if.sv
// Request/result bundle between the game controller and the trail collision
// scheduler: scan control, pig box, packed trail cells, and scan results.
interface trail_collision_scheduler_if #(
    parameter int TRAIL_POINTS = 16,
    parameter int BIT_WIDTH    = 5,
    parameter int COORD_W      = 10,
    parameter int IDX_W        = 4
);
    logic                              abort;
    logic                              scan_req;
    logic [COORD_W-1:0]                pigX;
    logic [COORD_W-1:0]                pigY;
    logic [COORD_W-1:0]                pigX_end;
    logic [COORD_W-1:0]                pigY_end;
    logic [TRAIL_POINTS*BIT_WIDTH-1:0] trailX;
    logic [TRAIL_POINTS*BIT_WIDTH-1:0] trailY;
    logic                              scan_busy;
    logic                              scan_done;
    logic                              hit;
    logic [IDX_W-1:0]                  hit_index;

    modport master (
        output abort, scan_req, pigX, pigY, pigX_end, pigY_end, trailX, trailY,
        input  scan_busy, scan_done, hit, hit_index
    );

    modport slave (
        input  abort, scan_req, pigX, pigY, pigX_end, pigY_end, trailX, trailY,
        output scan_busy, scan_done, hit, hit_index
    );
endinterface

// File: rtl/trail_collision_scheduler.sv
// Walks one shared rectangle-overlap comparator across a snapshot of the trail
// cells, one cell per cycle, and reports the lowest overlapping cell.
module trail_collision_scheduler #(
    parameter int TRAIL_POINTS = 16,
    parameter int BIT_WIDTH    = 5,
    parameter int TRAIL_WIDTH  = 20,
    parameter int EMPTY_CODE   = 31,
    parameter int COORD_W      = 10,
    parameter int IDX_W        = 4
) (
    input  logic                         clk,
    input  logic                         RST,
    trail_collision_scheduler_if.slave   bus
);
    localparam int VEC_W = TRAIL_POINTS * BIT_WIDTH;
    localparam int CW    = COORD_W + 2;

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pig_x;
        logic [COORD_W-1:0] pig_y;
        logic [COORD_W-1:0] pig_x_end;
        logic [COORD_W-1:0] pig_y_end;
        logic [VEC_W-1:0]   trail_x;
        logic [VEC_W-1:0]   trail_y;
    } snap_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             scan_done_q, scan_done_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_index_q, hit_index_d;
    snap_t            snap_q, snap_d;

    logic [BIT_WIDTH-1:0] cell_x, cell_y;
    logic                 cell_hit, last_cell;

    // Strict bounds: a box edge that only touches a cell edge is not an overlap.
    function automatic logic axis_overlap(input logic [COORD_W-1:0]   p,
                                          input logic [COORD_W-1:0]   pe,
                                          input logic [BIT_WIDTH-1:0] c);
        logic [CW-1:0] lo, hi, pw, pew;
        lo  = CW'(TRAIL_WIDTH) * CW'(c);
        hi  = lo + CW'(TRAIL_WIDTH);
        pw  = CW'(p);
        pew = CW'(pe);
        return (pw > lo && pw < hi) || (pew > lo && pew < hi) || (pw <= lo && pew >= hi);
    endfunction

    assign cell_x    = snap_q.trail_x[BIT_WIDTH*idx_q +: BIT_WIDTH];
    assign cell_y    = snap_q.trail_y[BIT_WIDTH*idx_q +: BIT_WIDTH];
    assign last_cell = (idx_q == IDX_W'(TRAIL_POINTS - 1));
    assign cell_hit  = (cell_x != BIT_WIDTH'(EMPTY_CODE)) && (cell_y != BIT_WIDTH'(EMPTY_CODE)) &&
                       axis_overlap(snap_q.pig_x, snap_q.pig_x_end, cell_x) &&
                       axis_overlap(snap_q.pig_y, snap_q.pig_y_end, cell_y);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        scan_done_d = 1'b0;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        case (state_q)
            IDLE: begin
                if (!bus.abort && bus.scan_req) begin
                    snap_d.pig_x     = bus.pigX;
                    snap_d.pig_y     = bus.pigY;
                    snap_d.pig_x_end = bus.pigX_end;
                    snap_d.pig_y_end = bus.pigY_end;
                    snap_d.trail_x   = bus.trailX;
                    snap_d.trail_y   = bus.trailY;
                    idx_d            = '0;
                    state_d          = SCAN;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cell_hit || last_cell) begin
                    scan_done_d = 1'b1;
                    hit_d       = cell_hit;
                    hit_index_d = cell_hit ? idx_q : '0;
                    state_d     = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            scan_done_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_done_q <= scan_done_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
        end
    end

    // NOTE: the snapshot is pure data, only read after it has been loaded on
    // entry to SCAN, so it carries no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign bus.scan_busy = (state_q == SCAN);
    assign bus.scan_done = scan_done_q;
    assign bus.hit       = hit_q;
    assign bus.hit_index = hit_index_q;
endmodule

// File: tb/tb_trail_collision_scheduler.sv
// Directed bench for trail_collision_scheduler: expected scan results are queued
// when a scan is launched and compared when scan_done arrives.
module tb_trail_collision_scheduler;
    localparam int TRAIL_POINTS = 16;
    localparam int BIT_WIDTH    = 5;
    localparam int TRAIL_WIDTH  = 20;
    localparam int EMPTY_CODE   = 31;
    localparam int COORD_W      = 10;
    localparam int IDX_W        = 4;

    typedef struct {
        string          tag;
        logic           hit;
        logic [IDX_W-1:0] idx;
        int             lat;
    } exp_t;

    logic clk = 1'b0;
    logic RST;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [BIT_WIDTH-1:0] tx[TRAIL_POINTS];
    logic [BIT_WIDTH-1:0] ty[TRAIL_POINTS];

    always #5 clk = ~clk;

    trail_collision_scheduler_if #(
        .TRAIL_POINTS(TRAIL_POINTS), .BIT_WIDTH(BIT_WIDTH), .COORD_W(COORD_W), .IDX_W(IDX_W)
    ) bus ();

    trail_collision_scheduler #(
        .TRAIL_POINTS(TRAIL_POINTS), .BIT_WIDTH(BIT_WIDTH), .TRAIL_WIDTH(TRAIL_WIDTH),
        .EMPTY_CODE(EMPTY_CODE), .COORD_W(COORD_W), .IDX_W(IDX_W)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_trail();
        for (int i = 0; i < TRAIL_POINTS; i++) begin
            tx[i] = BIT_WIDTH'(EMPTY_CODE);
            ty[i] = BIT_WIDTH'(EMPTY_CODE);
        end
    endtask

    task automatic apply_trail();
        for (int i = 0; i < TRAIL_POINTS; i++) begin
            bus.trailX[BIT_WIDTH*i +: BIT_WIDTH] = tx[i];
            bus.trailY[BIT_WIDTH*i +: BIT_WIDTH] = ty[i];
        end
    endtask

    task automatic set_pig(input int x, input int y, input int xe, input int ye);
        bus.pigX     = COORD_W'(x);
        bus.pigY     = COORD_W'(y);
        bus.pigX_end = COORD_W'(xe);
        bus.pigY_end = COORD_W'(ye);
    endtask

    // Called #1 after an edge; the request is accepted at the next edge (E0).
    task automatic launch(input string tag);
        apply_trail();
        bus.scan_req = 1'b1;
        @(posedge clk);
        #1;
        bus.scan_req = 1'b0;
        check({tag, "_busy_start"}, bus.scan_busy, 1);
        check({tag, "_done_low_start"}, bus.scan_done, 0);
    endtask

    task automatic start_scan(input string tag, input logic h, input int idx, input int lat);
        exp_t e;
        e.tag = tag;
        e.hit = h;
        e.idx = IDX_W'(idx);
        e.lat = lat;
        sb.push_back(e);
        launch(tag);
    endtask

    // already = edges after E0 that the caller has stepped through itself.
    task automatic wait_done(input int already);
        exp_t e;
        int   n;
        bit   seen;
        n    = already;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.scan_done;
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, seen, 1);
        check({e.tag, "_latency"}, n, e.lat);
        check({e.tag, "_hit"}, bus.hit, e.hit);
        check({e.tag, "_hit_index"}, bus.hit_index, e.idx);
        check({e.tag, "_busy_in_done"}, bus.scan_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        RST          = 1'b0;
        bus.abort    = 1'b0;
        bus.scan_req = 1'b1;
        clear_trail();
        apply_trail();
        set_pig(100, 100, 119, 119);

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_busy", bus.scan_busy, 0);
            check("rst_done", bus.scan_done, 0);
            check("rst_hit", bus.hit, 0);
            check("rst_hit_index", bus.hit_index, 0);
        end

        RST = 1'b1;
        start_scan("all_empty", 1'b0, 0, 16);
        wait_done(0);

        // Back-to-back from the done cycle; cell 9 also overlaps but 5 is lower.
        clear_trail();
        tx[5] = 5'd5; ty[5] = 5'd5;
        tx[9] = 5'd6; ty[9] = 5'd6;
        set_pig(105, 105, 124, 124);
        start_scan("hit5", 1'b1, 5, 6);
        wait_done(0);

        clear_trail();
        tx[2] = 5'd3; ty[2] = 5'd3;
        set_pig(80, 80, 99, 99);
        start_scan("edge_touch", 1'b0, 0, 16);
        wait_done(0);

        clear_trail();
        tx[15] = 5'd0; ty[15] = 5'd0;
        set_pig(0, 0, 19, 19);
        start_scan("last_cell", 1'b1, 15, 16);
        wait_done(0);

        // Mid-scan input change and scan_req pulses must not affect the result.
        clear_trail();
        set_pig(105, 105, 124, 124);
        start_scan("snapshot", 1'b0, 0, 16);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tx[10] = 5'd5; ty[10] = 5'd5;
        apply_trail();
        bus.scan_req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.scan_req = 1'b0;
        check("snapshot_busy_mid", bus.scan_busy, 1);
        wait_done(5);
        @(posedge clk);
        #1;
        check("no_queue_busy", bus.scan_busy, 0);
        check("no_queue_done", bus.scan_done, 0);

        clear_trail();
        tx[3] = 5'd5; ty[3] = 5'd5;
        set_pig(105, 105, 124, 124);
        start_scan("hit3", 1'b1, 3, 4);
        wait_done(0);

        // Abort while evaluating idx 7 of a scan that would find nothing.
        clear_trail();
        launch("abort_scan");
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_before", bus.scan_busy, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy", bus.scan_busy, 0);
        check("abort_hit_kept", bus.hit, 1);
        check("abort_index_kept", bus.hit_index, 3);
        done_seen = 1'b0;
        repeat (20) begin
            done_seen |= bus.scan_done;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", done_seen, 0);

        // abort in IDLE drops a simultaneous request.
        bus.abort    = 1'b1;
        bus.scan_req = 1'b1;
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.scan_req = 1'b0;
        check("idle_abort_busy", bus.scan_busy, 0);

        clear_trail();
        tx[3] = 5'd5; ty[3] = 5'd5;
        set_pig(105, 105, 124, 124);
        start_scan("after_abort", 1'b1, 3, 4);
        wait_done(0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
